// File: rtl/cv32e40p_apu_wb_buffer.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_wb_buffer
//
// Result-side companion of the APU dispatcher. APU responses (result, fflags,
// destination register) are written into register-file port B. LSU writeback
// has strict priority on that port. Responses that cannot be written at once
// go into a small in-order FIFO. Occupancy, full and read-dependency
// indications are fed back to the ID stage.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   apu_rvalid_i           APU response valid (single-cycle pulse)
//   apu_result_i           APU result data
//   apu_flags_i            APU fflags
//   apu_waddr_i            destination register of the response
//   lsu_we_i               LSU owns port B this cycle
//   read_regs_i            three ID-stage source register addresses
//   read_regs_valid_i      per-source valid
//   wb_we_o                port B write enable
//   wb_waddr_o             port B write address
//   wb_wdata_o             port B write data
//   fflags_we_o            fflags update enable (same as wb_we_o)
//   fflags_o               fflags of the result being written
//   count_o                number of buffered results
//   full_o                 buffer holds DEPTH results
//   almost_full_o          buffer holds at least DEPTH-1 results
//   read_dep_o             a pending result targets a valid ID source
//   overflow_o             sticky: a response was dropped while full
// ---------------------------------------------------------------------------
module cv32e40p_apu_wb_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 5,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        apu_result_i,
  input  logic [FLAG_WIDTH-1:0]        apu_flags_i,
  input  logic [ADDR_WIDTH-1:0]        apu_waddr_i,
  input  logic                         lsu_we_i,
  input  logic [2:0][ADDR_WIDTH-1:0]   read_regs_i,
  input  logic [2:0]                   read_regs_valid_i,
  output logic                         wb_we_o,
  output logic [ADDR_WIDTH-1:0]        wb_waddr_o,
  output logic [DATA_WIDTH-1:0]        wb_wdata_o,
  output logic                         fflags_we_o,
  output logic [FLAG_WIDTH-1:0]        fflags_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         almost_full_o,
  output logic                         read_dep_o,
  output logic                         overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(DEPTH-1);

  // Control state (reset)
  logic [AW-1:0]    rptr, wptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic             overflow;

  // Entry payload (not reset; qualified by valid/count)
  logic [DATA_WIDTH-1:0] result_q [DEPTH];
  logic [FLAG_WIDTH-1:0] flags_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] waddr_q  [DEPTH];

  logic port_free, empty, full, bypass, deq, enq, drop;

  assign port_free = !lsu_we_i;
  assign empty     = (count == '0);
  assign full      = (count == FULL_C);

  // The bypass is only legal while empty, so older buffered results are
  // always written before a newer response.
  assign bypass = empty && apu_rvalid_i && port_free;
  assign deq    = !empty && port_free;
  // A full buffer still accepts a response when the head leaves this cycle.
  assign enq    = apu_rvalid_i && !bypass && (!full || deq);
  assign drop   = apu_rvalid_i && full && !deq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      valid    <= '0;
      overflow <= 1'b0;
    end else begin
      // Dequeue clears first so a same-slot enqueue (full & deq) wins.
      if (deq) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + AW'(1);
      end
      if (enq) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + AW'(1);
      end
      count    <= count + CW'(enq) - CW'(deq);
      overflow <= overflow | drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      result_q[wptr] <= apu_result_i;
      flags_q[wptr]  <= apu_flags_i;
      waddr_q[wptr]  <= apu_waddr_i;
    end
  end

  // Port B drive: buffered head first, otherwise the bypassed response.
  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    fflags_o   = '0;
    if (deq) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = waddr_q[rptr];
      wb_wdata_o = result_q[rptr];
      fflags_o   = flags_q[rptr];
    end else if (bypass) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = apu_waddr_i;
      wb_wdata_o = apu_result_i;
      fflags_o   = apu_flags_i;
    end
  end

  // A result is still pending if it sits in the buffer and is not being
  // written this cycle, or if it arrives now and is not bypassed.
  always_comb begin
    read_dep_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (read_regs_valid_i[i]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (valid[e] && !(deq && (rptr == AW'(e))) &&
              (read_regs_i[i] == waddr_q[e]))
            read_dep_o = 1'b1;
        end
        if (apu_rvalid_i && !bypass && (read_regs_i[i] == apu_waddr_i))
          read_dep_o = 1'b1;
      end
    end
  end

  assign fflags_we_o   = wb_we_o;
  assign count_o       = count;
  assign full_o        = full;
  assign almost_full_o = (count >= AF_C);
  assign overflow_o    = overflow;

endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_apu_wb_buffer
//
// Directed checks of the APU writeback buffer (bypass, buffering behind the
// LSU, simultaneous enqueue/dequeue, overflow and reset, read dependency)
// followed by a random run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_cv32e40p_apu_wb_buffer;

  localparam int DW = 32;
  localparam int FW = 5;
  localparam int AW = 6;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              apu_rvalid;
  logic [DW-1:0]     apu_result;
  logic [FW-1:0]     apu_flags;
  logic [AW-1:0]     apu_waddr;
  logic              lsu_we;
  logic [2:0][AW-1:0] read_regs;
  logic [2:0]        read_regs_valid;
  logic              wb_we;
  logic [AW-1:0]     wb_waddr;
  logic [DW-1:0]     wb_wdata;
  logic              fflags_we;
  logic [FW-1:0]     fflags;
  logic [CW-1:0]     count;
  logic              full;
  logic              almost_full;
  logic              read_dep;
  logic              overflow;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cv32e40p_apu_wb_buffer #(
    .DATA_WIDTH(DW), .FLAG_WIDTH(FW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result),
    .apu_flags_i(apu_flags), .apu_waddr_i(apu_waddr),
    .lsu_we_i(lsu_we),
    .read_regs_i(read_regs), .read_regs_valid_i(read_regs_valid),
    .wb_we_o(wb_we), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata),
    .fflags_we_o(fflags_we), .fflags_o(fflags),
    .count_o(count), .full_o(full), .almost_full_o(almost_full),
    .read_dep_o(read_dep), .overflow_o(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [FW-1:0] f);
    apu_rvalid = 1'b1;
    apu_waddr  = a;
    apu_result = d;
    apu_flags  = f;
  endtask

  // Reference model state for the random run
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [FW-1:0] f;
  } ent_t;
  ent_t q[$];
  ent_t cur;

  initial begin
    rst = 1'b1; apu_rvalid = 1'b0; apu_result = '0; apu_flags = '0;
    apu_waddr = '0; lsu_we = 1'b0; read_regs = '0; read_regs_valid = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_we", 64'(wb_we), 0);
    chk("rst_wdata", 64'(wb_wdata), 0);
    chk("rst_waddr", 64'(wb_waddr), 0);
    chk("rst_af", 64'(almost_full), 0);

    // 1: bypass
    resp(6'd5, 32'hDEADBEEF, 5'h1);
    #1;
    chk("byp_we", 64'(wb_we), 1);
    chk("byp_fwe", 64'(fflags_we), 1);
    chk("byp_waddr", 64'(wb_waddr), 5);
    chk("byp_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    chk("byp_flags", 64'(fflags), 1);
    step();
    apu_rvalid = 1'b0;
    #1;
    chk("byp_count", 64'(count), 0);

    // 2: buffer two responses behind the LSU
    lsu_we = 1'b1;
    resp(6'd3, 32'h3333, 5'h3);
    #1;
    chk("lsu_we0", 64'(wb_we), 0);
    step();
    resp(6'd4, 32'h4444, 5'h4);
    #1;
    chk("lsu_count1", 64'(count), 1);
    chk("lsu_af1", 64'(almost_full), 1);
    chk("lsu_full1", 64'(full), 0);
    step();
    apu_rvalid = 1'b0;
    #1;
    chk("lsu_count2", 64'(count), 2);
    chk("lsu_full2", 64'(full), 1);
    chk("lsu_we2", 64'(wb_we), 0);
    step();
    lsu_we = 1'b0;
    #1;
    chk("drain_we0", 64'(wb_we), 1);
    chk("drain_a0", 64'(wb_waddr), 3);
    chk("drain_d0", 64'(wb_wdata), 32'h3333);
    step();
    chk("drain_we1", 64'(wb_we), 1);
    chk("drain_a1", 64'(wb_waddr), 4);
    chk("drain_f1", 64'(fflags), 4);
    chk("drain_c1", 64'(count), 1);
    step();
    chk("drain_c2", 64'(count), 0);
    chk("drain_we2", 64'(wb_we), 0);

    // 3: simultaneous enqueue and dequeue
    lsu_we = 1'b1;
    resp(6'd7, 32'h7777, 5'h7);
    step();
    lsu_we = 1'b0;
    resp(6'd8, 32'h8888, 5'h8);
    #1;
    chk("sim_a7", 64'(wb_waddr), 7);
    chk("sim_d7", 64'(wb_wdata), 32'h7777);
    chk("sim_c0", 64'(count), 1);
    step();
    apu_rvalid = 1'b0;
    #1;
    chk("sim_c1", 64'(count), 1);
    chk("sim_we8", 64'(wb_we), 1);
    chk("sim_a8", 64'(wb_waddr), 8);
    chk("sim_d8", 64'(wb_wdata), 32'h8888);
    step();
    chk("sim_c2", 64'(count), 0);

    // 5: read dependency
    lsu_we = 1'b1;
    read_regs = '0;
    read_regs[1] = 6'd10;
    read_regs_valid = 3'b010;
    resp(6'd10, 32'hAAAA, 5'h0);
    #1;
    chk("dep_incoming", 64'(read_dep), 1);
    step();
    apu_rvalid = 1'b0;
    #1;
    chk("dep_buffered", 64'(read_dep), 1);
    read_regs_valid = 3'b000;
    #1;
    chk("dep_novalid", 64'(read_dep), 0);
    read_regs_valid = 3'b101;
    #1;
    chk("dep_othersrc", 64'(read_dep), 0);
    read_regs_valid = 3'b010;
    lsu_we = 1'b0;
    #1;
    chk("dep_deq", 64'(read_dep), 0);
    chk("dep_deq_a", 64'(wb_waddr), 10);
    step();
    read_regs_valid = 3'b000;
    chk("dep_c", 64'(count), 0);

    // 4: overflow and reset
    lsu_we = 1'b1;
    resp(6'd1, 32'h1111, 5'h1);
    step();
    resp(6'd2, 32'h2222, 5'h2);
    step();
    resp(6'd9, 32'h9999, 5'h9);
    #1;
    chk("ovf_before", 64'(overflow), 0);
    step();
    apu_rvalid = 1'b0;
    #1;
    chk("ovf_set", 64'(overflow), 1);
    chk("ovf_count", 64'(count), 2);
    step();
    chk("ovf_sticky", 64'(overflow), 1);
    lsu_we = 1'b0;
    #1;
    chk("ovf_a1", 64'(wb_waddr), 1);
    step();
    chk("ovf_a2", 64'(wb_waddr), 2);
    chk("ovf_d2", 64'(wb_wdata), 32'h2222);
    step();
    chk("ovf_nodrop_we", 64'(wb_we), 0);
    chk("ovf_still", 64'(overflow), 1);
    lsu_we = 1'b1;
    resp(6'd1, 32'h1234, 5'h1);
    step();
    apu_rvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    lsu_we = 1'b0;
    #1;
    chk("rst2_count", 64'(count), 0);
    chk("rst2_ovf", 64'(overflow), 0);
    chk("rst2_we", 64'(wb_we), 0);

    // 6: random traffic against a queue model
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      lsu_we = ($urandom_range(0, 2) == 0);
      apu_rvalid = ($urandom_range(0, 1) == 1);
      if (lsu_we && q.size() == DEPTH) apu_rvalid = 1'b0;
      apu_waddr  = AW'($urandom);
      apu_result = $urandom;
      apu_flags  = FW'($urandom);
      #1;
      chk("rnd_count", 64'(count), 64'(q.size()));
      if (!lsu_we && q.size() > 0) begin
        cur = q.pop_front();
        chk("rnd_we", 64'(wb_we), 1);
        chk("rnd_waddr", 64'(wb_waddr), 64'(cur.a));
        chk("rnd_wdata", 64'(wb_wdata), 64'(cur.d));
        chk("rnd_flags", 64'(fflags), 64'(cur.f));
        if (apu_rvalid) q.push_back({apu_waddr, apu_result, apu_flags});
      end else if (!lsu_we && apu_rvalid) begin
        chk("rnd_byp_we", 64'(wb_we), 1);
        chk("rnd_byp_d", 64'(wb_wdata), 64'(apu_result));
      end else begin
        chk("rnd_idle_we", 64'(wb_we), 0);
        if (apu_rvalid) q.push_back({apu_waddr, apu_result, apu_flags});
      end
      step();
    end
    apu_rvalid = 1'b0;
    #1;
    chk("rnd_no_ovf", 64'(overflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
